// File: rtl/stopwatch_pkg.sv
// Shared definitions for the SS.hh stopwatch: FSM encoding, BCD digit limits
// and the position of each digit inside the packed display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TSEC_MAX  = 4'd5;

  localparam int DIG_HUND_LSB  = 0;
  localparam int DIG_TENTH_LSB = 4;
  localparam int DIG_SEC_LSB   = 8;
  localparam int DIG_TSEC_LSB  = 12;

  // Digit index 0 is hundredths, index 3 is tens of seconds.
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx == NUM_DIGITS - 1) ? TSEC_MAX : DIGIT_MAX;
  endfunction

  function automatic int digit_lsb(input int idx);
    case (idx)
      0:       return DIG_HUND_LSB;
      1:       return DIG_TENTH_LSB;
      2:       return DIG_SEC_LSB;
      default: return DIG_TSEC_LSB;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_bcd_btn_debounce.sv
// One push-button input path: 2-FF synchronizer, 1 ms sampled debouncer and
// a single-cycle pulse on each accepted rising edge of the stable level.
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms_i,
  input  logic btn_i,
  output logic press_o
);
  import stopwatch_pkg::*;

  localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // cnt_q holds how many consecutive samples already disagreed with stable_q.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (ce1ms_i) begin
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q;
          cnt_d    = '0;
          press_d  = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// Seconds/hundredths stopwatch producing packed BCD SS.hh for the display
// driver, timed only by the driver's 1 ms count-enable.
module stopwatch_bcd #(
  parameter int CE_PER_TICK = 10,
  parameter int DEB_MS      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] dat,
  output logic        running,
  output logic        ovf
);
  import stopwatch_pkg::*;

  localparam int PW = (CE_PER_TICK > 1) ? $clog2(CE_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CE_PER_TICK - 1);

  logic            p_ss;
  logic            p_clr;
  sw_state_e       state_q;
  sw_state_e       state_d;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic            tick;
  logic            ovf_q;
  logic            ovf_d;
  logic [NUM_DIGITS:0] carry;

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .ce1ms_i (ce1ms),
    .btn_i   (btn_ss),
    .press_o (p_ss)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_clr (
    .clk     (clk),
    .rst     (rst),
    .ce1ms_i (ce1ms),
    .btn_i   (btn_clr),
    .press_o (p_clr)
  );

  // Clear has priority over start/stop in the same cycle.
  always_comb begin
    state_d = state_q;
    if (p_clr) begin
      state_d = ST_IDLE;
    end else if (p_ss) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prescaler only moves in RUN, so a partial tick survives PAUSE.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (p_clr) begin
      presc_d = '0;
    end else if (state_q == ST_RUN && ce1ms) begin
      if (presc_q == PRESC_TERM) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign carry[0] = tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam int LSB = digit_lsb(gi);
      localparam logic [3:0] LIMIT = digit_limit(gi);

      logic [3:0] digit_q;
      logic [3:0] digit_d;
      logic       at_max;

      assign at_max       = (digit_q >= LIMIT);
      assign carry[gi+1]  = carry[gi] & at_max;

      always_comb begin
        digit_d = digit_q;
        if (p_clr) begin
          digit_d = 4'd0;
        end else if (carry[gi]) begin
          digit_d = at_max ? 4'd0 : digit_q + 4'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          digit_q <= 4'd0;
        end else begin
          digit_q <= digit_d;
        end
      end

      assign dat[LSB +: DIGIT_W] = digit_q;
    end
  endgenerate

  // A carry out of the top digit is the 59.99 -> 00.00 wrap.
  always_comb begin
    ovf_d = ovf_q;
    if (p_clr) begin
      ovf_d = 1'b0;
    end else if (carry[NUM_DIGITS]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed vector table for the timing scenarios,
// a reset-on-terminal-tick sequence, then random buttons against a model.
module tb_stopwatch_bcd;

  localparam int CPT = 2;
  localparam int DEB = 3;
  localparam int NV  = 29;
  localparam int NRND = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1ms;
  logic        btn_ss;
  logic        btn_clr;
  logic [15:0] dat;
  logic        running;
  logic        ovf;

  int n_total = 0;
  int n_bad   = 0;

  stopwatch_bcd #(.CE_PER_TICK(CPT), .DEB_MS(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce1ms   (ce1ms),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .dat     (dat),
    .running (running),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        clr;
    int          n;
    logic [15:0] dat;
    logic        run;
    logic        ovf;
  } vec_t;

  vec_t tbl [NV];

  // Model state: centisecond count derived from 1 ms enables seen in RUN.
  bit model_on = 1'b0;
  bit lvl_ss   = 1'b0;
  bit lvl_clr  = 1'b0;
  int m_mode   = 0;
  int m_ce     = 0;
  bit m_stab [2];
  int m_nv   [2];
  bit m_hist [2][DEB];

  function automatic logic [15:0] to_bcd(input int cs);
    int s;
    s = cs % 6000;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic deb_sample(input int b, input bit s, output bit press);
    bit all_diff;
    press = 1'b0;
    for (int k = DEB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
    m_hist[b][0] = s;
    if (m_nv[b] < DEB) m_nv[b]++;
    all_diff = (m_nv[b] == DEB);
    for (int k = 0; k < DEB; k++) if (m_hist[b][k] == m_stab[b]) all_diff = 1'b0;
    if (all_diff) begin
      m_stab[b] = s;
      press     = s;
    end
  endtask

  task automatic model_ce();
    bit pss;
    bit pclr;
    if (m_mode == 1) m_ce++;
    deb_sample(0, lvl_ss, pss);
    deb_sample(1, lvl_clr, pclr);
    if (pclr) begin
      m_mode = 0;
      m_ce   = 0;
    end else if (pss) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  // One 5-cycle ce1ms period; buttons change right after the enable.
  task automatic period(input logic ss, input logic clr);
    @(negedge clk);
    ce1ms = 1'b1;
    if (model_on) model_ce();
    @(negedge clk);
    ce1ms   = 1'b0;
    btn_ss  = ss;
    btn_clr = clr;
    lvl_ss  = ss;
    lvl_clr = clr;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic r_ss;
    logic r_clr;

    tbl[0]  = '{1'b1, 1'b0, 1,     16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4,     16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5,     16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 199,   16'h0100, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4,     16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4,     16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4,     16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3,     16'h0001, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4,     16'h0003, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 50,    16'h0003, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 3,     16'h0003, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3,     16'h0003, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1,     16'h0003, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1,     16'h0004, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4,     16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4,     16'h0000, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 4,     16'h0000, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 11999, 16'h5999, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 4,     16'h0000, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4,     16'h0000, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 4,     16'h0000, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 2464,  16'h1232, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 1'b1, 3,     16'h1233, 1'b1, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 1,     16'h0000, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 4,     16'h0000, 1'b0, 1'b0};
    tbl[27] = '{1'b1, 1'b0, 4,     16'h0000, 1'b1, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 85,    16'h0042, 1'b1, 1'b0};

    rst     = 1'b1;
    ce1ms   = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk16("reset_dat", dat, 16'h0000);
    chk1("reset_running", running, 1'b0);
    chk1("reset_ovf", ovf, 1'b0);
    $display("reset dat=%h running=%b ovf=%b", dat, running, ovf);

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tbl[i].n; k++) period(tbl[i].ss, tbl[i].clr);
      chk16($sformatf("vec%0d_dat", i), dat, tbl[i].dat);
      chk1($sformatf("vec%0d_running", i), running, tbl[i].run);
      chk1($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
      $display("vec %0d ss=%b clr=%b n=%0d dat=%h/%h running=%b/%b ovf=%b/%b",
               i, tbl[i].ss, tbl[i].clr, tbl[i].n, dat, tbl[i].dat,
               running, tbl[i].run, ovf, tbl[i].ovf);
    end

    // Reset lands on the same edge as a terminal enable at 00.42.
    @(negedge clk);
    ce1ms = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    ce1ms = 1'b0;
    rst   = 1'b0;
    chk16("rst_tick_dat", dat, 16'h0000);
    chk1("rst_tick_running", running, 1'b0);
    chk1("rst_tick_ovf", ovf, 1'b0);
    $display("rst_on_tick dat=%h running=%b ovf=%b", dat, running, ovf);
    repeat (3) period(1'b0, 1'b0);
    chk16("rst_idle_dat", dat, 16'h0000);
    chk1("rst_idle_running", running, 1'b0);
    $display("post_rst_idle dat=%h running=%b", dat, running);

    model_on = 1'b1;
    m_mode   = 0;
    m_ce     = 0;
    for (int b = 0; b < 2; b++) begin
      m_stab[b] = 1'b0;
      m_nv[b]   = 0;
      for (int k = 0; k < DEB; k++) m_hist[b][k] = 1'b0;
    end
    r_ss  = 1'b0;
    r_clr = 1'b0;
    for (int i = 0; i < NRND; i++) begin
      if ($urandom_range(3) == 0) r_ss = ~r_ss;
      if (r_clr) begin
        if ($urandom_range(3) == 0) r_clr = 1'b0;
      end else if ($urandom_range(11) == 0) begin
        r_clr = 1'b1;
      end
      period(r_ss, r_clr);
      chk16("rnd_dat", dat, to_bcd(m_ce / CPT));
      chk1("rnd_running", running, m_mode == 1);
      chk1("rnd_ovf", ovf, (m_ce / CPT) >= 6000);
      $display("rnd %0d ss=%b clr=%b dat=%h/%h running=%b/%b", i, r_ss, r_clr,
               dat, to_bcd(m_ce / CPT), running, m_mode == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
